// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the 3x3 convolution row sequencer.
package conv_seq_pkg;

    localparam int PIX_W    = 8;
    localparam int TAPS     = 3;
    localparam int KROW_W   = TAPS * PIX_W;
    localparam int KERNEL_W = KROW_W * TAPS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_FINISH
    } seq_state_t;

    // Kernel row k occupies bits [24k+23:24k].
    function automatic logic [KROW_W-1:0] kernel_row(input logic [KERNEL_W-1:0] kernel,
                                                     input logic [1:0]          k);
        return kernel[KROW_W*k +: KROW_W];
    endfunction

endpackage

// File: rtl/conv_tap_align.sv
// Fixed-depth delay line that lines up {acc, weight} with data returning
// from the input BRAM. Cleared asynchronously by reset and synchronously by flush.
module conv_tap_align #(
    parameter int DEPTH = 1,
    parameter int W     = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    // Shift the tap controls one stage per cycle; flush drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/conv_row_sequencer.sv
// Row scheduler for the 3x3 convolution engine: three input-row reads per
// output row, tap controls delayed to meet the BRAM data, one output write per row.
// Optional abort input is enabled with the CONV_SEQ_ABORT_EN macro.
//
// state  | meaning
// IDLE   | waiting for start; kernel latched on acceptance
// CLEAR  | one-cycle accumulator clear for the current row
// FETCH  | three input reads, rows r, r+1, r+2
// DRAIN  | wait for last tap data and engine result (RD_LAT+CONV_LAT cycles)
// WRITE  | one output-BRAM write at address r
// FINISH | one-cycle done pulse, then back to IDLE
module conv_row_sequencer
    import conv_seq_pkg::*;
#(
    parameter int OUT_ROWS = 128,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int CONV_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KERNEL_W-1:0] kernel,
`ifdef CONV_SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic                in_en,
    output logic [ADDR_W-1:0]   in_addr,
    output logic                conv_clr,
    output logic                conv_acc,
    output logic [KROW_W-1:0]   conv_weight,
    output logic                out_we,
    output logic [ADDR_W-1:0]   out_addr
);

    localparam int DRAIN_CYC = RD_LAT + CONV_LAT;
    localparam int DRAIN_W   = 3;
    localparam logic [ADDR_W-1:0]  LAST_ROW  = ADDR_W'(OUT_ROWS - 1);
    localparam logic [1:0]         LAST_TAP  = 2'(TAPS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_TOP = DRAIN_W'(DRAIN_CYC - 1);

    if ((OUT_ROWS + 1) > ((1 << ADDR_W) - 1)) begin : g_addr_check
        $error("conv_row_sequencer: OUT_ROWS+1 does not fit in ADDR_W bits");
    end
    if (RD_LAT < 1 || RD_LAT > 3 || CONV_LAT < 1 || CONV_LAT > 3) begin : g_lat_check
        $error("conv_row_sequencer: RD_LAT and CONV_LAT must be 1..3");
    end

    seq_state_t          state;
    logic [ADDR_W-1:0]   row;
    logic [1:0]          tap;
    logic [1:0]          next_tap;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [KERNEL_W-1:0] kernel_q;
    logic [KROW_W-1:0]   tap_weight;
    logic                abort_hit;

    assign next_tap = tap + 2'd1;

`ifdef CONV_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Sequencer FSM; every output is registered and set on the edge entering its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            row        <= '0;
            tap        <= '0;
            drain_cnt  <= '0;
            kernel_q   <= '0;
            tap_weight <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_en      <= 1'b0;
            in_addr    <= '0;
            conv_clr   <= 1'b0;
            out_we     <= 1'b0;
            out_addr   <= '0;
        end else begin
            done       <= 1'b0;
            in_en      <= 1'b0;
            conv_clr   <= 1'b0;
            out_we     <= 1'b0;
            tap_weight <= '0;
            if (abort_hit) begin
                state    <= S_IDLE;
                row      <= '0;
                busy     <= 1'b0;
                in_addr  <= '0;
                out_addr <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            kernel_q <= kernel;
                            row      <= '0;
                            busy     <= 1'b1;
                            conv_clr <= 1'b1;
                            state    <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        tap        <= 2'd0;
                        in_en      <= 1'b1;
                        in_addr    <= row;
                        tap_weight <= kernel_row(kernel_q, 2'd0);
                        state      <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (tap == LAST_TAP) begin
                            drain_cnt <= DRAIN_TOP;
                            state     <= S_DRAIN;
                        end else begin
                            tap        <= next_tap;
                            in_en      <= 1'b1;
                            in_addr    <= row + ADDR_W'(next_tap);
                            tap_weight <= kernel_row(kernel_q, next_tap);
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == '0) begin
                            out_we   <= 1'b1;
                            out_addr <= row;
                            state    <= S_WRITE;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (row == LAST_ROW) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FINISH;
                        end else begin
                            row      <= row + 1'b1;
                            conv_clr <= 1'b1;
                            state    <= S_CLEAR;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The read enable doubles as the accumulate strobe once delayed by the BRAM latency.
    conv_tap_align #(
        .DEPTH (RD_LAT),
        .W     (KROW_W + 1)
    ) u_tap_align (
        .clk   (clk),
        .reset (reset),
        .flush (abort_hit),
        .d     ({in_en, tap_weight}),
        .q     ({conv_acc, conv_weight})
    );

endmodule

// File: doc/conv_row_sequencer.md
# conv_row_sequencer

Row-level scheduler for the 3x3 convolution datapath. Latches a 72-bit kernel on `start`, walks the 130-row input BRAM three rows per output row, and drives the clear, weight and accumulate controls of the 128-lane convolution engine. Issues one output-BRAM write per finished row and reports completion with `done`. Replaces the split input/output control pair with one sequencer that owns both BRAM address streams.

## Interface
- `OUT_ROWS`, 128: output rows per frame; input rows = `OUT_ROWS`+2
- `ADDR_W`, 8: BRAM address width
- `RD_LAT`, 1: input-BRAM read latency in cycles (1..3)
- `CONV_LAT`, 1: cycles from last accumulate to valid engine result (1..3)
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: frame request; sampled only in IDLE
- `kernel` in 72: nine 8-bit weights; row k = `kernel[24k+23:24k]`
- `busy` out 1: high from the cycle after accepted `start` until `done`
- `done` out 1: one-cycle pulse after the last row write
- `in_en` out 1: input-BRAM read enable
- `in_addr` out ADDR_W: input-BRAM row address
- `conv_clr` out 1: clears engine accumulators
- `conv_acc` out 1: engine accumulates current data × `conv_weight`
- `conv_weight` out 24: kernel row aligned with returning BRAM data
- `out_we` out 1: output-BRAM write enable; data = engine result
- `out_addr` out ADDR_W: output-BRAM row address

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, WRITE, FINISH.
- IDLE: `start`=1 latches `kernel` and sets row r=0 -> CLEAR.
- CLEAR: `conv_clr`=1 for one cycle -> FETCH with tap k=0.
- FETCH: 3 cycles, k=0,1,2: `in_en`=1, `in_addr`=r+k. -> DRAIN after k=2.
- `conv_acc` and `conv_weight`=kernel row k are delayed RD_LAT cycles from the matching `in_en`, so each tap is aligned with its data.
- DRAIN: RD_LAT+CONV_LAT cycles. -> WRITE.
- WRITE: `out_we`=1, `out_addr`=r for one cycle. If r=OUT_ROWS-1 -> FINISH, else r+1 -> CLEAR.
- FINISH: `done`=1 for one cycle, `busy`=0 -> IDLE.
- Arithmetic: r and r+k are ADDR_W-bit unsigned. The largest address is OUT_ROWS+1 and must fit in ADDR_W; this is an elaboration check. No wrap-around occurs.
- `start` outside IDLE is ignored. `start` held high in FINISH is not accepted until IDLE, so there is no back-to-back restart in the same cycle.
- The kernel latch is stable for the whole frame. `kernel` changes mid-frame have no effect.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE, r=0, delay pipe cleared. All outputs 0, including `in_addr`, `out_addr` and `conv_weight`.
- Reset mid-frame: all outputs 0 immediately. No partial `out_we` and no `done`.
- Per-row period = 1+3+RD_LAT+CONV_LAT+1 cycles (7 at defaults).
- Frame latency from accepted `start` to `done` = OUT_ROWS×period+1 cycles (897 at defaults).
- `busy` rises the cycle after accepted `start` and falls together with the `done` pulse.

## Configuration
- `CONV_SEQ_ABORT_EN` defined: adds input `abort` (1 bit).
  - In any non-IDLE state, `abort`=1 forces IDLE next cycle.
  - `in_en`, `conv_acc`, `out_we` and `busy` read 0 from that cycle on, and the delay pipe is flushed.
  - No `done` is issued.
  - `abort` in IDLE is ignored.
  - `abort` and `start` together in IDLE: `start` wins.
- Undefined: no `abort` port. Frames always run to completion.

## Structure
- Package `conv_seq_pkg`:
  - state enum
  - `KROW_W`=24, `TAPS`=3, `PIX_W`=8
  - function extracting kernel row k
- Sub-module `conv_tap_align`: RD_LAT-deep shift register carrying {acc, 24-bit weight}, with async active-low clear.

## Test plan
- Reset, then `start` with kernel = 0x010203_040506_070809 -> first row:
  - `in_addr` 0,1,2 on consecutive cycles
  - `conv_weight` 0x070809, 0x040506, 0x010203 each RD_LAT cycles later with `conv_acc`=1
  - `out_we` at `out_addr`=0 in cycle 7
- Full frame at defaults -> exactly 128 `out_we` pulses, addresses 0..127 ascending. Max `in_addr` = 129. `done` 897 cycles after `start`.
- `start` pulsed mid-frame and `kernel` changed mid-frame -> no restart. All rows use the latched kernel. Write count is still 128.
- RD_LAT=3, CONV_LAT=2 -> period 10 cycles, weight/acc 3 cycles after each `in_en`, `done` at 1281.
- `reset` low during row 5 FETCH -> outputs 0 asynchronously. After release, a new `start` begins at `in_addr` 0.
- With `CONV_SEQ_ABORT_EN`, `abort` in row 3 DRAIN -> IDLE next cycle, no `out_we` for row 3, no `done`. The following `start` runs a full frame.
